sigmoid_backward: RTL and testbench
===================================

# sigmoid_backward

Serial backward-pass unit for the Q8.8 sigmoid activation. It accepts a forward activation y and an upstream gradient g, and returns the local derivative d = y·(1−y) and the propagated gradient g·d. Both results are computed with a shared shift-add datapath. The block sits in the training path after the forward sigmoid stage and uses a valid/ready handshake on each side.

## Interface
- No parameters. The number format is fixed: 16-bit Q8.8, where 0x0100 = 1.0.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operands valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- y_in  input  16  forward activation, unsigned Q8.8, nominal 0x0000..0x0100
- grad_in  input  16  upstream gradient, signed Q8.8
- out_valid  output  1  results valid
- out_ready  input  1  downstream accepts results
- deriv_out  output  16  d = y·(1−y), unsigned Q8.8, range 0x0000..0x0040
- grad_out  output  16  grad_in·d, signed Q8.8

## Operation
- States: IDLE → DERIV → SCALE → DONE → IDLE.
- **IDLE:** in_ready=1. Acceptance happens when in_valid && in_ready on a rising edge.
  - y_in and grad_in are captured on that edge; later input changes are ignored.
  - y is clamped: y_c = (y_in > 0x0100) ? 0x0100 : y_in, comparing unsigned.
  - a = y_c (9 bits), b = 0x100 − y_c (9 bits).
- **DERIV:** 9 iterations, one per cycle, LSB-first on b. Computes p = a·b (at most 16384, 15 bits).
  - d = p >> 8, truncated. 8-bit shared counter.
- **SCALE:** 7 iterations, LSB-first on d (7 bits, at most 64). Computes q = grad_in·d as a signed 23-bit value.
  - result = q >>> 8, arithmetic shift, truncation toward −∞.
  - |result| ≤ 8192, so it never overflows 16 bits and no saturation logic is present.
- **DONE:**
  - out_valid=1; deriv_out = {8'h00, d}; grad_out = result.
  - Outputs are held stable while out_ready=0.
  - When out_valid && out_ready, the block returns to IDLE and out_valid drops on that edge.
- Values of deriv_out/grad_out outside DONE are don't-care for consumers, but they are registered and hold their last values.
- Reset values: in_ready=1 (state IDLE), out_valid=0, deriv_out=0x0000, grad_out=0x0000, counter=0, accumulators=0.
- Reset mid-operation asynchronously discards the in-flight operation. No partial result is ever presented.

## Timing
- Acceptance edge = E0.
- Edges E1..E9 execute DERIV; E10..E16 execute SCALE.
- At E16 the state becomes DONE and out_valid rises, giving a latency of 16 cycles.
- The output handshake completes on the first edge Ek ≥ E17 where out_ready=1. in_ready=1 from that edge onward.
- The earliest next acceptance is E18, so maximum throughput is one operation per 18 cycles.
- in_ready=0 from E0 through the handshake edge. in_valid asserted during that window is ignored (not accepted).
- A simultaneous out_ready and in_valid in DONE does not accept the new input in the same cycle.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- Macro: `SIGMOID_BWD_ROUND_EN`.
- **Defined:** both right shifts round half-up by adding 0x80 before shifting.
  - d = (p + 128) >> 8
  - result = (q + 128) >>> 8
  - Ranges are unchanged: d ≤ 64, no overflow.
- **Undefined:** both shifts truncate as described in Operation.
- Latency and handshake are identical in both builds.

## Test plan
- **Basic case.** y_in=0x0080, grad_in=0x0100 → deriv_out=0x0040, grad_out=0x0040. out_valid rises exactly 16 edges after acceptance.
- **Negative gradient.** y_in=0x0040, grad_in=0xFF00 → deriv_out=0x0030, grad_out=0xFFD0, in both builds.
- **Clamp and endpoints.** y_in ∈ {0x0000, 0x0100, 0x0200, 0xFFFF}, grad_in=0x7FFF → deriv_out=0x0000, grad_out=0x0000.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid rises → outputs stable and in_ready=0 throughout. in_valid pulses during this window are not accepted. in_ready=1 one edge after out_ready rises.
- **Reset mid-operation.** Assert rst_n=0 at E8 → out_valid=0, outputs 0x0000, in_ready=1 immediately. A new operation after release yields correct results.
- **Rounding macro.** y_in=0x0001, grad_in=0x7FFF:
  - Without macro → deriv_out=0x0000, grad_out=0x0000.
  - With `SIGMOID_BWD_ROUND_EN` → deriv_out=0x0001, grad_out=0x0080.

Source files
------------

// File: rtl/sigmoid_backward.sv
// Serial Q8.8 sigmoid backward unit: d = y*(1-y) and grad_in*d via a shift-add datapath.
// Optional build macro SIGMOID_BWD_ROUND_EN selects round-half-up instead of truncation on both shifts.
module sigmoid_backward (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] y_in,
    input  logic [15:0] grad_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] deriv_out,
    output logic [15:0] grad_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DERIV = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [8:0]         a_q, a_d;
    logic [8:0]         b_q, b_d;
    logic [15:0]        g_q, g_d;
    logic [14:0]        p_q, p_d;
    logic [6:0]         dv_q, dv_d;
    logic signed [22:0] q_q, q_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        deriv_q, deriv_d;
    logic [15:0]        gout_q, gout_d;

    logic [8:0]         y_c_s;
    logic [14:0]        p_add_s, p_next_s, p_rnd_s;
    logic signed [22:0] q_add_s, q_next_s, q_rnd_s;
    logic               unused_s;

    // Shift-add step for both phases, plus the optional rounding offset.
    always_comb begin
        y_c_s    = (y_in > 16'h0100) ? 9'h100 : y_in[8:0];
        // a<<cnt is only added when b[cnt] is set, so the partial sum stays below a*b <= 16384
        p_add_s  = {6'd0, a_q} << cnt_q[3:0];
        p_next_s = b_q[cnt_q[3:0]] ? (p_q + p_add_s) : p_q;
        q_add_s  = $signed({{7{g_q[15]}}, g_q}) <<< cnt_q[2:0];
        q_next_s = dv_q[cnt_q[2:0]] ? (q_q + q_add_s) : q_q;
`ifdef SIGMOID_BWD_ROUND_EN
        p_rnd_s  = p_next_s + 15'd128;
        q_rnd_s  = q_next_s + 23'sd128;
`else
        p_rnd_s  = p_next_s;
        q_rnd_s  = q_next_s;
`endif
    end

    assign unused_s = ^{p_rnd_s[7:0], q_rnd_s[7:0]};

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        g_d         = g_q;
        p_d         = p_q;
        dv_d        = dv_q;
        q_d         = q_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        deriv_d     = deriv_q;
        gout_d      = gout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = y_c_s;
                    b_d        = 9'h100 - y_c_s;
                    g_d        = grad_in;
                    p_d        = 15'd0;
                    q_d        = 23'sd0;
                    cnt_d      = 8'd0;
                    in_ready_d = 1'b0;
                    state_d    = S_DERIV;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_DERIV: begin
                p_d = p_next_s;
                if (cnt_q == 8'd8) begin
                    dv_d    = p_rnd_s[14:8];
                    cnt_d   = 8'd0;
                    state_d = S_SCALE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_SCALE: begin
                q_d = q_next_s;
                if (cnt_q == 8'd6) begin
                    // |q>>>8| <= 8192, so the 15 significant bits sign-extend to 16 without saturation
                    deriv_d     = {9'd0, dv_q};
                    gout_d      = {q_rnd_s[22], q_rnd_s[22:8]};
                    out_valid_d = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d       = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            a_q         <= 9'd0;
            b_q         <= 9'd0;
            g_q         <= 16'd0;
            p_q         <= 15'd0;
            dv_q        <= 7'd0;
            q_q         <= 23'sd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            deriv_q     <= 16'd0;
            gout_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            g_q         <= g_d;
            p_q         <= p_d;
            dv_q        <= dv_d;
            q_q         <= q_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            deriv_q     <= deriv_d;
            gout_q      <= gout_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign deriv_out = deriv_q;
    assign grad_out  = gout_q;

endmodule

// File: tb/tb_sigmoid_backward.sv
// Self-checking bench for sigmoid_backward with a queue-based scoreboard.
// Honours SIGMOID_BWD_ROUND_EN the same way the design does.
module tb_sigmoid_backward;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_in;
    logic [15:0] grad_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] deriv_out;
    logic [15:0] grad_out;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          accept_cyc   = 0;
    logic [31:0] exp_q[$];

    sigmoid_backward dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .grad_in   (grad_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .deriv_out (deriv_out),
        .grad_out  (grad_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic reference: {deriv, grad} for one operation.
    function automatic logic [31:0] model(input logic [15:0] y, input logic [15:0] g);
        int yc, p, d, q, r;
        yc = (y > 16'h0100) ? 256 : int'(y);
        p  = yc * (256 - yc);
`ifdef SIGMOID_BWD_ROUND_EN
        d  = (p + 128) >>> 8;
        q  = int'($signed(g)) * d;
        r  = (q + 128) >>> 8;
`else
        d  = p >>> 8;
        q  = int'($signed(g)) * d;
        r  = q >>> 8;
`endif
        return {d[15:0], r[15:0]};
    endfunction

    task automatic send(input logic [15:0] y, input logic [15:0] g, input logic [31:0] expv);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        y_in     = y;
        grad_in  = g;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid   = 1'b0;
        y_in       = 16'hDEAD;
        grad_in    = 16'hBEEF;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; y_in = 16'h0; grad_in = 16'h0;
        #12;
        tests_run++;
        if ({in_ready, out_valid, deriv_out, grad_out} !== {1'b1, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b d=%h g=%h required 1 0 0000 0000",
                     in_ready, out_valid, deriv_out, grad_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat; logic [31:0] e;
        send(16'h0080, 16'h0100, 32'h0040_0040);
        wait_out(lat);
        tests_run++;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d required 16", lat);
        end
        e = exp_q.pop_front();
        tests_run++;
        if ({deriv_out, grad_out} !== e) begin
            tests_failed++;
            $display("FAIL basic_result: got %h_%h required %h", deriv_out, grad_out, e);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_handshake: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_negative;
        int lat; logic [31:0] e;
        send(16'h0040, 16'hFF00, 32'h0030_FFD0);
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || {deriv_out, grad_out} !== e) begin
            tests_failed++;
            $display("FAIL negative_grad: got vld=%b %h_%h required %h", out_valid, deriv_out, grad_out, e);
        end
    endtask

    task automatic test_clamp;
        logic [15:0] ys [4] = '{16'h0000, 16'h0100, 16'h0200, 16'hFFFF};
        int lat; logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            send(ys[i], 16'h7FFF, 32'h0000_0000);
            wait_out(lat);
            e = exp_q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || {deriv_out, grad_out} !== e) begin
                tests_failed++;
                $display("FAIL clamp_y%h: got vld=%b %h_%h required %h", ys[i], out_valid, deriv_out, grad_out, e);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat; int seen; logic [31:0] e; logic [31:0] snap;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h00C0, 16'h1234, model(16'h00C0, 16'h1234));
        wait_out(lat);
        snap = {deriv_out, grad_out};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; y_in = 16'h0010; grad_in = 16'h0100;
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {deriv_out, grad_out} !== snap) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b %h_%h required 1 0 %h",
                         i, out_valid, in_ready, deriv_out, grad_out, snap);
            end
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        tests_run++;
        if (snap !== e) begin
            tests_failed++;
            $display("FAIL bp_result: got %h required %h", snap, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL bp_no_accept: got spurious out_valid=%0d required 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] e;
        send(16'h0070, 16'h0200, model(16'h0070, 16'h0200));
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        tests_run++;
        if ({in_ready, out_valid, deriv_out, grad_out} !== {1'b1, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_mid: got rdy=%b vld=%b d=%h g=%h required 1 0 0000 0000",
                     in_ready, out_valid, deriv_out, grad_out);
        end
        @(negedge clk); rst_n = 1'b1;
        send(16'h0020, 16'hFC00, model(16'h0020, 16'hFC00));
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== 16 || {deriv_out, grad_out} !== e) begin
            tests_failed++;
            $display("FAIL reset_recover: got lat=%0d %h_%h required 16 %h", lat, deriv_out, grad_out, e);
        end
    endtask

    task automatic test_rounding;
        int lat; logic [31:0] e;
`ifdef SIGMOID_BWD_ROUND_EN
        send(16'h0001, 16'h7FFF, 32'h0001_0080);
`else
        send(16'h0001, 16'h7FFF, 32'h0000_0000);
`endif
        wait_out(lat);
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || {deriv_out, grad_out} !== e) begin
            tests_failed++;
            $display("FAIL rounding: got vld=%b %h_%h required %h", out_valid, deriv_out, grad_out, e);
        end
    endtask

    task automatic test_back_to_back;
        int lat; int prev; logic [31:0] e; logic [15:0] y; logic [15:0] g;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            y = 16'($urandom_range(0, 300));
            g = 16'($urandom);
            send(y, g, model(y, g));
            if (prev >= 0) begin
                tests_run++;
                if (accept_cyc - prev !== 18) begin
                    tests_failed++;
                    $display("FAIL b2b_gap%0d: got %0d cycles required 18", i, accept_cyc - prev);
                end
            end
            prev = accept_cyc;
            wait_out(lat);
            e = exp_q.pop_front();
            tests_run++;
            if (lat !== 16 || {deriv_out, grad_out} !== e) begin
                tests_failed++;
                $display("FAIL b2b_op%0d y=%h g=%h: got lat=%0d %h_%h required 16 %h",
                         i, y, g, lat, deriv_out, grad_out, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_rounding();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
